// File: rtl/serial_logic_unit8_pkg.sv
// Shared opcodes and FSM encoding for the
// bit-serial logic unit.
package serial_logic_unit8_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_logic_unit8_bit_cell.sv
// 1-bit logic cell: NAND-based gates plus a
// 4:1 select on the opcode.
module gate_nand2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module gate_not1 (
  input  logic a,
  output logic y
);
  gate_nand2 u_n (.a(a), .b(a), .y(y));
endmodule

module gate_and2 (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n;
  gate_nand2 u_n (.a(a), .b(b), .y(n));
  gate_not1  u_i (.a(n), .y(y));
endmodule

module gate_or2 (
  input  logic a,
  input  logic b,
  output logic y
);
  logic na, nb;
  gate_not1  u_ia (.a(a), .y(na));
  gate_not1  u_ib (.a(b), .y(nb));
  gate_nand2 u_n  (.a(na), .b(nb), .y(y));
endmodule

module gate_xor2 (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n0, n1, n2;
  gate_nand2 u_0 (.a(a),  .b(b),  .y(n0));
  gate_nand2 u_1 (.a(a),  .b(n0), .y(n1));
  gate_nand2 u_2 (.a(b),  .b(n0), .y(n2));
  gate_nand2 u_3 (.a(n1), .b(n2), .y(y));
endmodule

module logic_bit_cell (
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  output logic       r
);
  import serial_logic_unit8_pkg::*;

  logic y_and, y_or, y_xor, y_not;

  gate_and2 u_and (.a(a), .b(b), .y(y_and));
  gate_or2  u_or  (.a(a), .b(b), .y(y_or));
  gate_xor2 u_xor (.a(a), .b(b), .y(y_xor));
  gate_not1 u_not (.a(a), .y(y_not));

  always_comb begin
    r = 1'b0;
    unique case (1'b1)
      op == OP_AND: r = y_and;
      op == OP_OR:  r = y_or;
      op == OP_XOR: r = y_xor;
      op == OP_NOT: r = y_not;
      default:      r = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_logic_unit8.sv
// Bit-serial WIDTH-bit logic unit: LSB-first,
// one bit per clock through a single cell.
module serial_logic_unit8 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             busy
);
  import serial_logic_unit8_pkg::*;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [WIDTH-1:0] res_n;
  logic [CNT_W-1:0] count;
  logic [1:0]       op_q;
  logic             r, last;

  logic_bit_cell u_cell (
    .op (op_q),
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .r  (r)
  );

  assign last  = (count == LAST);
  assign res_n = {r, r_sh[WIDTH-1:1]};

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (in_valid) state_n = S_RUN;
      S_RUN:  if (last)     state_n = S_DONE;
      S_DONE: if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      op_q  <= OP_AND;
      f     <= '0;
      zero  <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            op_q  <= op;
            count <= '0;
          end
        end
        S_RUN: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          r_sh <= res_n;
          // wrap to 0 so count never passes WIDTH-1
          if (last) begin
            count <= '0;
            f     <= res_n;
            zero  <= ~|res_n;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
